// File: rtl/port1_serial_rx_pkg.sv
// Shared Port-1 serial definitions: receiver FSM encodings and frame line polarities.
// The transmit side uses the same encodings and levels.
package port1_serial_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/port1_serial_rx_bit_sync.sv
// Multi-flop synchronizer for the asynchronous P1 pin.
// It resets to the idle line level so reset release never fakes a start edge.
module port1_bit_sync
  import port1_serial_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stages <= {SYNC_STAGES{IDLE_LVL}};
    else      stages <= {stages[SYNC_STAGES-2:0], d};
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/port1_serial_rx.sv
// Port-1 receiver: deserializes UART-style frames on p1_in into a one-deep CPU buffer with sticky errors.
// Define PORT1_PARITY_EN to add an even-parity bit after the data and make parity_err live.
module port1_serial_rx
  import port1_serial_rx_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BIT_DIV     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p1_in,
  input  logic              p1_out_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(BIT_DIV);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic              s_in, s_in_prev, start_edge;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              half_tick, bit_tick;
  logic              data_smp, stop_smp, word_done, deliver_pend;
  logic              frame_set, ovr_set;
`ifdef PORT1_PARITY_EN
  logic              par_smp, par_set, par_bad;
`endif

  port1_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (p1_in),
    .q   (s_in)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_in_prev <= IDLE_LVL;
    else      s_in_prev <= s_in;
  end

  assign start_edge = (s_in_prev == IDLE_LVL) && (s_in == START_LVL);
  assign half_tick  = (cnt == HALF_LAST);
  assign bit_tick   = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_nxt;
  end

  // The pin being driven by the MCU aborts any frame in progress, whatever the state.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:   if (start_edge && !p1_out_en) state_nxt = RX_START;
      RX_START:  if (half_tick) state_nxt = (s_in == START_LVL) ? RX_DATA : RX_IDLE;
      RX_DATA: begin
        if (data_smp && (bit_idx == IDX_LAST)) begin
`ifdef PORT1_PARITY_EN
          state_nxt = RX_PARITY;
`else
          state_nxt = RX_STOP;
`endif
        end
      end
      RX_PARITY: if (bit_tick) state_nxt = RX_STOP;
      RX_STOP:   if (bit_tick) state_nxt = RX_IDLE;
      default:   state_nxt = RX_IDLE;
    endcase
    if ((state != RX_IDLE) && p1_out_en) state_nxt = RX_IDLE;
  end

  always_comb begin
    rx_busy  = (state != RX_IDLE);
    data_smp = 1'b0;
    stop_smp = 1'b0;
`ifdef PORT1_PARITY_EN
    par_smp  = 1'b0;
`endif
    if (bit_tick && !p1_out_en) begin
      data_smp = (state == RX_DATA);
      stop_smp = (state == RX_STOP);
`ifdef PORT1_PARITY_EN
      par_smp  = (state == RX_PARITY);
`endif
    end
  end

  // cnt restarts on every state change and wraps per bit period while the state holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               cnt <= '0;
    else if ((state_nxt != state) || (state == RX_IDLE))    cnt <= '0;
    else if (bit_tick)                                      cnt <= '0;
    else                                                    cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == RX_START) begin
      bit_idx <= '0;
    end else if (data_smp) begin
      bit_idx <= bit_idx + IDX_W'(1);
      shreg   <= {s_in, shreg[DATA_W-1:1]};
    end
  end

`ifdef PORT1_PARITY_EN
  assign par_set = par_smp && ((^shreg) != s_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   par_bad <= 1'b0;
    else if (state == RX_START) par_bad <= 1'b0;
    else if (par_set)           par_bad <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= par_set || (parity_err && !err_clr);
  end

  assign word_done = stop_smp && (s_in == IDLE_LVL) && !par_bad;
`else
  assign parity_err = 1'b0;
  assign word_done  = stop_smp && (s_in == IDLE_LVL);
`endif

  // shreg stays untouched until the next frame's first data sample, so it is delivered directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) deliver_pend <= 1'b0;
    else      deliver_pend <= word_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (deliver_pend) begin
      if (!rx_valid || rx_ack) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  assign frame_set = stop_smp && (s_in == START_LVL);
  assign ovr_set   = deliver_pend && rx_valid && !rx_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set || (frame_err && !err_clr);
      overrun   <= ovr_set || (overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_port1_serial_rx.sv
// Bench for port1_serial_rx: directed frames plus random traffic, checked every cycle against a frame-level timing model.
// Define PORT1_PARITY_EN to build and check the parity variant.
`timescale 1ns/1ps
module tb_port1_serial_rx;

  localparam int DATA_W      = 16;
  localparam int BIT_DIV     = 16;
  localparam int SYNC_STAGES = 2;
`ifdef PORT1_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Offset from the first busy cycle to the stop-bit sample.
  localparam int STOP_OFS = BIT_DIV / 2 + (DATA_W + PAR_BITS + 1) * BIT_DIV;
  localparam int LATENCY  = 281 + PAR_BITS * BIT_DIV;

  logic              clk = 1'b0, rst = 1'b0, p1_in = 1'b1, p1_out_en = 1'b0;
  logic              rx_ack = 1'b0, err_clr = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_busy, frame_err, overrun, parity_err;

  port1_serial_rx #(.DATA_W(DATA_W), .BIT_DIV(BIT_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .p1_in      (p1_in),
    .p1_out_en  (p1_out_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  logic        m_valid = 1'b0, m_busy = 1'b0, m_frame = 1'b0, m_ovr = 1'b0, m_par = 1'b0, m_ovr_set;
  logic [15:0] m_data = '0;
  logic [15:0] ev_deliver [int];
  bit          ev_frame [int];
  bit          ev_par [int];
  bit          ev_busy_on [int];
  bit          ev_busy_off [int];

  int   n_cmp = 0, n_fail = 0, n_print = 0;
  int   busy_rise = -1, valid_rise = -1;
  logic prev_busy = 1'b0, prev_valid = 1'b0;
  bit   rand_en = 1'b0;

  // Frame-level model: events scheduled by the stimulus at their predicted cycles are applied here.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      m_valid = 1'b0; m_data = '0; m_busy = 1'b0;
      m_frame = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
    end else begin
      m_ovr_set = 1'b0;
      if (ev_deliver.exists(cyc)) begin
        if (!m_valid || rx_ack) begin
          m_data  = ev_deliver[cyc];
          m_valid = 1'b1;
        end else begin
          m_ovr_set = 1'b1;
        end
      end else if (rx_ack) begin
        m_valid = 1'b0;
      end
      m_frame = ev_frame.exists(cyc) || (m_frame && !err_clr);
      m_ovr   = m_ovr_set || (m_ovr && !err_clr);
      m_par   = ev_par.exists(cyc) || (m_par && !err_clr);
      if (ev_busy_on.exists(cyc))  m_busy = 1'b1;
      if (ev_busy_off.exists(cyc)) m_busy = 1'b0;
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      if (n_print < 40) begin
        n_print = n_print + 1;
        $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
    end
  endtask

  // One clock step: compare against the model, track rising edges, then drive random handshakes.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      checkOutput("rx_valid",   32'(rx_valid),   32'(m_valid));
      checkOutput("rx_data",    32'(rx_data),    32'(m_data));
      checkOutput("rx_busy",    32'(rx_busy),    32'(m_busy));
      checkOutput("frame_err",  32'(frame_err),  32'(m_frame));
      checkOutput("overrun",    32'(overrun),    32'(m_ovr));
      checkOutput("parity_err", 32'(parity_err), 32'(m_par));
    end
    if (rx_busy && !prev_busy)   busy_rise  = cyc;
    if (rx_valid && !prev_valid) valid_rise = cyc;
    prev_busy  = rx_busy;
    prev_valid = rx_valid;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    if (rand_en) begin
      if (m_valid && ($urandom_range(0, 299) == 0)) rx_ack = 1'b1;
      if ($urandom_range(0, 399) == 0) err_clr = 1'b1;
    end
  endtask

  task automatic pulseAck();
    tick();
    rx_ack = 1'b1;
    tick();
  endtask

  task automatic pulseClear();
    tick();
    err_clr = 1'b1;
    tick();
  endtask

  // Drive one frame and schedule its outcome: busy from k = drive+3 (two sync flops plus edge detect).
  task automatic applyStimulus(input logic [15:0] w, input logic stop_b, input logic par_ok, input int gap);
    logic [DATA_W+2:0] bits;
    int nb;
    int k;
    bits = '0;
    nb = 0;
    bits[nb] = 1'b0;
    nb++;
    for (int i = 0; i < DATA_W; i++) begin
      bits[nb] = w[i];
      nb++;
    end
    if (PAR_BITS == 1) begin
      bits[nb] = (^w) ^ !par_ok;
      nb++;
    end
    bits[nb] = stop_b;
    nb++;
    tick();
    k = cyc + 3;
    ev_busy_on[k] = 1'b1;
    ev_busy_off[k + STOP_OFS] = 1'b1;
    if (PAR_BITS == 1 && !par_ok) ev_par[k + STOP_OFS - BIT_DIV] = 1'b1;
    if (!stop_b) ev_frame[k + STOP_OFS] = 1'b1;
    else if (PAR_BITS == 0 || par_ok) ev_deliver[k + STOP_OFS + 1] = w;
    for (int i = 0; i < nb; i++) begin
      p1_in = bits[i];
      repeat (BIT_DIV) tick();
    end
    p1_in = 1'b1;
    repeat (gap) tick();
  endtask

  initial begin
    logic [15:0] w;
    int k;
    $display("[TB] start, parity bits = %0d", PAR_BITS);
    #1;
    checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset rx_data",  32'(rx_data),  32'd0);
    checkOutput("reset rx_busy",  32'(rx_busy),  32'd0);
    checkOutput("reset flags",    {29'd0, frame_err, overrun, parity_err}, 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();

    // 1: good frame, latency and ack
    busy_rise = -1; valid_rise = -1;
    applyStimulus(16'hA5C3, 1'b1, 1'b1, 2);
    checkOutput("t1 rx_data",  32'(rx_data),  32'h0000A5C3);
    checkOutput("t1 rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("t1 latency",  32'(valid_rise - busy_rise), 32'(LATENCY));
    pulseAck();
    checkOutput("t1 ack clears valid", 32'(rx_valid), 32'd0);

    // 2: overrun keeps the first word
    applyStimulus(16'h1234, 1'b1, 1'b1, 0);
    applyStimulus(16'hBEEF, 1'b1, 1'b1, 2);
    checkOutput("t2 rx_data kept", 32'(rx_data), 32'h00001234);
    checkOutput("t2 overrun",      32'(overrun), 32'd1);
    pulseClear();
    checkOutput("t2 overrun cleared", 32'(overrun), 32'd0);
    pulseAck();

    // 3: bad stop bit, then recovery
    applyStimulus(16'h00FF, 1'b0, 1'b1, 4);
    checkOutput("t3 frame_err", 32'(frame_err), 32'd1);
    checkOutput("t3 no valid",  32'(rx_valid),  32'd0);
    applyStimulus(16'h0F0F, 1'b1, 1'b1, 2);
    checkOutput("t3 next word", 32'(rx_data),   32'h00000F0F);
    checkOutput("t3 sticky",    32'(frame_err), 32'd1);
    pulseClear();
    pulseAck();

    // 4: short low pulse is a glitch
    tick();
    p1_in = 1'b0;
    k = cyc + 3;
    ev_busy_on[k] = 1'b1;
    ev_busy_off[k + BIT_DIV / 2] = 1'b1;
    repeat (6) tick();
    p1_in = 1'b1;
    repeat (20) tick();
    checkOutput("t4 no valid", 32'(rx_valid), 32'd0);
    checkOutput("t4 no busy",  32'(rx_busy),  32'd0);
    checkOutput("t4 no flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

    // 5: MCU takes the pin during data bit 5 of 16'hFFFF
    tick();
    p1_in = 1'b0;
    k = cyc + 3;
    ev_busy_on[k] = 1'b1;
    repeat (BIT_DIV) tick();
    p1_in = 1'b1;
    repeat (5 * BIT_DIV + BIT_DIV / 2) tick();
    p1_out_en = 1'b1;
    ev_busy_off[cyc + 1] = 1'b1;
    tick();
    checkOutput("t5 busy dropped", 32'(rx_busy), 32'd0);
    tick();
    p1_out_en = 1'b0;
    repeat (40) tick();
    checkOutput("t5 no flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    applyStimulus(16'h8001, 1'b1, 1'b1, 2);
    checkOutput("t5 next word", 32'(rx_data), 32'h00008001);

`ifdef PORT1_PARITY_EN
    // 6: parity mismatch discards the word, a correct parity bit delivers it
    pulseAck();
    applyStimulus(16'h0001, 1'b1, 1'b0, 2);
    checkOutput("t6 parity_err", 32'(parity_err), 32'd1);
    checkOutput("t6 no valid",   32'(rx_valid),   32'd0);
    applyStimulus(16'h0001, 1'b1, 1'b1, 2);
    checkOutput("t6 good word",  32'(rx_data),    32'h00000001);
    pulseClear();
`endif

    // Reset pulled mid-frame while a word is still held
    tick();
    p1_in = 1'b0;
    ev_busy_on[cyc + 3] = 1'b1;
    repeat (4 * BIT_DIV) tick();
    rst = 1'b0;
    #1;
    checkOutput("rst rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst rx_data",  32'(rx_data),  32'd0);
    checkOutput("rst rx_busy",  32'(rx_busy),  32'd0);
    p1_in = 1'b1;
    ev_deliver.delete(); ev_frame.delete(); ev_par.delete();
    ev_busy_on.delete(); ev_busy_off.delete();
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();
    applyStimulus(16'h5A5A, 1'b1, 1'b1, 2);
    checkOutput("post-reset word", 32'(rx_data), 32'h00005A5A);
    pulseAck();

    // Random traffic with random acks and clears
    rand_en = 1'b1;
    for (int n = 0; n < 14; n++) begin
      w = 16'($urandom);
      applyStimulus(w, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 24));
    end
    rand_en = 1'b0;
    repeat (10) tick();
    pulseAck();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
